// File: rtl/mem_dev_if.sv
// Command/data bus between a memory controller and mem_dev_responder.
// The master modport is the controller side and the slave modport is the device side.
interface mem_dev_if;
    logic        cs_n;
    logic [2:0]  command;
    logic [3:0]  RA;
    logic [11:0] CA;
    logic        dq_i;
    logic        dq_o;
    logic        dq_oe;
    logic        busy;
    logic        err;

    modport master (
        output cs_n, command, RA, CA, dq_i,
        input  dq_o, dq_oe, busy, err
    );

    modport slave (
        input  cs_n, command, RA, CA, dq_i,
        output dq_o, dq_oe, busy, err
    );
endinterface

// File: rtl/mem_dev_responder.sv
// Serial memory device model with ACT/RD/WR/PRE commands and 32-bit LSB-first data bursts.
// Defining MEM_RESP_PARITY_EN adds a 33rd even-parity bit to every burst.
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | no row open; only ACT is accepted
// S_ACTIVE   | row open; accepts ACT, PRE, RD and WR
// S_WR_SHIFT | shifting in serial write data
// S_RD_WAIT  | waiting out the RD_LATENCY cycles
// S_RD_SHIFT | driving serial read data onto dq_o
module mem_dev_responder #(
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_dev_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RESP_PARITY_EN
    localparam int BURST = 33;
`else
    localparam int BURST = 32;
`endif
    localparam int CW = $clog2(BURST);
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_RD  = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_WR_SHIFT,
        S_RD_WAIT,
        S_RD_SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [2:0]       lat_q, lat_d;
    logic [BURST-1:0] wsh_q, wsh_d;
    logic [BURST-1:0] rsh_q, rsh_d;
    logic             dq_o_q, dq_o_d;
    logic             dq_oe_q, dq_oe_d;
    logic             err_q, err_d;
    logic [31:0]      mem_q [DEPTH];

    logic             cmd_vld;
    logic [15:0]      addr_full;
    logic [AW-1:0]    cmd_idx;
    logic             mem_we;
    logic             wr_ok;

    assign cmd_vld   = !bus.cs_n && (bus.command != CMD_NOP);
    assign addr_full = {row_q, bus.CA};
    assign cmd_idx   = AW'(addr_full);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        lat_d   = lat_q;
        wsh_d   = wsh_q;
        rsh_d   = rsh_q;
        dq_o_d  = 1'b0;
        dq_oe_d = 1'b0;
        err_d   = err_q;
        mem_we  = 1'b0;
        wr_ok   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    if (bus.command == CMD_ACT) begin
                        row_d   = bus.RA;
                        state_d = S_ACTIVE;
                    end else if (bus.command != CMD_PRE) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (cmd_vld) begin
                    case (bus.command)
                        CMD_ACT: row_d = bus.RA;
                        CMD_PRE: state_d = S_IDLE;
                        CMD_WR: begin
                            idx_d   = cmd_idx;
                            bit_d   = '0;
                            state_d = S_WR_SHIFT;
                        end
                        CMD_RD: begin
                            idx_d = cmd_idx;
                            bit_d = '0;
`ifdef MEM_RESP_PARITY_EN
                            rsh_d = {^mem_q[cmd_idx], mem_q[cmd_idx]};
`else
                            rsh_d = mem_q[cmd_idx];
`endif
                            if (RD_LATENCY == 0) begin
                                state_d = S_RD_SHIFT;
                            end else begin
                                lat_d   = 3'(RD_LATENCY);
                                state_d = S_RD_WAIT;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_WR_SHIFT: begin
                if (cmd_vld) err_d = 1'b1;
                wsh_d = {bus.dq_i, wsh_q[BURST-1:1]};
                if (bit_q == LAST) begin
`ifdef MEM_RESP_PARITY_EN
                    wr_ok = ((^wsh_d[31:0]) == wsh_d[32]);
`endif
                    mem_we  = wr_ok;
                    if (!wr_ok) err_d = 1'b1;
                    state_d = S_ACTIVE;
                end else begin
                    bit_d = bit_q + CW'(1);
                end
            end
            S_RD_WAIT: begin
                if (cmd_vld) err_d = 1'b1;
                if (lat_q <= 3'd1) begin
                    state_d = S_RD_SHIFT;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_RD_SHIFT: begin
                if (cmd_vld) err_d = 1'b1;
                // The first shift edge only puts bit 0 on the bus; bit_q then tracks the bit being driven.
                if (!dq_oe_q) begin
                    dq_oe_d = 1'b1;
                    dq_o_d  = rsh_q[0];
                    rsh_d   = rsh_q >> 1;
                    bit_d   = '0;
                end else if (bit_q == LAST) begin
                    state_d = S_ACTIVE;
                end else begin
                    dq_oe_d = 1'b1;
                    dq_o_d  = rsh_q[0];
                    rsh_d   = rsh_q >> 1;
                    bit_d   = bit_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            lat_q   <= '0;
            wsh_q   <= '0;
            rsh_q   <= '0;
            dq_o_q  <= 1'b0;
            dq_oe_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            lat_q   <= lat_d;
            wsh_q   <= wsh_d;
            rsh_q   <= rsh_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (mem_we) begin
            mem_q[idx_q] <= wsh_d[31:0];
        end
    end

    assign bus.dq_o  = dq_o_q;
    assign bus.dq_oe = dq_oe_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q == S_WR_SHIFT) || (state_q == S_RD_WAIT) ||
                       (state_q == S_RD_SHIFT);
endmodule

// File: tb/tb_mem_dev_responder.sv
// Directed bench for mem_dev_responder: vector table plus hand-written corner sequences.
// Defining MEM_RESP_PARITY_EN enables the parity-burst sequence.
module tb_mem_dev_responder;
    localparam int LAT = 2;
`ifdef MEM_RESP_PARITY_EN
    localparam int BURST = 33;
`else
    localparam int BURST = 32;
`endif
    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_RD  = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b100;

    logic clk;
    logic rst_n;
    mem_dev_if bus ();

    mem_dev_responder #(.DEPTH(16), .RD_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef enum {OP_RST, OP_RAW, OP_DESEL, OP_WR, OP_RD} op_t;
    typedef struct {
        op_t         op;
        logic [2:0]  cmd;
        logic [3:0]  ra;
        logic [11:0] ca;
        logic [31:0] data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {28'd0, bus.dq_o, bus.dq_oe, bus.busy, bus.err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_raw(input logic [2:0] cmd, input logic [3:0] ra, input logic [11:0] ca,
                          input logic desel, input string nm);
        int oe_seen;
        bus.cs_n    = desel;
        bus.command = cmd;
        bus.RA      = ra;
        bus.CA      = ca;
        step();
        bus.cs_n    = 1'b1;
        bus.command = CMD_NOP;
        oe_seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (bus.dq_oe !== 1'b0 || bus.busy !== 1'b0) oe_seen++;
            step();
        end
        chk({nm, "_quiet"}, 32'(oe_seen), 32'd0);
    endtask

    task automatic do_wr(input logic [11:0] ca, input logic [31:0] data, input logic par_bad,
                         input int inj_bit);
        bus.cs_n    = 1'b0;
        bus.command = CMD_WR;
        bus.CA      = ca;
        step();
        bus.cs_n    = 1'b1;
        bus.command = CMD_NOP;
        for (int k = 0; k < BURST; k++) begin
            if (k < 32) bus.dq_i = data[k];
            else        bus.dq_i = (^data) ^ par_bad;
            if (k == inj_bit) begin
                bus.cs_n    = 1'b0;
                bus.command = CMD_ACT;
                bus.RA      = 4'd9;
            end
            step();
            bus.cs_n    = 1'b1;
            bus.command = CMD_NOP;
            if (k == 0) chk("wr_busy", {31'd0, bus.busy}, 32'd1);
        end
        chk("wr_done_busy", {31'd0, bus.busy}, 32'd0);
        bus.dq_i = 1'b0;
    endtask

    task automatic do_rd(input logic [11:0] ca, input logic [31:0] exp_v, input string nm,
                         input int abort_bit);
        logic [31:0] got;
        logic        par;
        int          oe_bad;
        got = '0;
        par = 1'b0;
        oe_bad = 0;
        bus.cs_n    = 1'b0;
        bus.command = CMD_RD;
        bus.CA      = ca;
        step();
        bus.cs_n    = 1'b1;
        bus.command = CMD_NOP;
        for (int e = 0; e < LAT; e++) begin
            step();
            if (bus.dq_oe !== 1'b0) oe_bad++;
        end
        for (int k = 0; k < BURST; k++) begin
            step();
            if (bus.dq_oe !== 1'b1) oe_bad++;
            if (k < 32) got[k] = bus.dq_o;
            else        par = bus.dq_o;
            if (k == abort_bit) begin
                chk({nm, "_pre_abort_oe"}, 32'(oe_bad), 32'd0);
                rst_n = 1'b0;
                #1;
                chk({nm, "_abort_oe"}, {31'd0, bus.dq_oe}, 32'd0);
                chk({nm, "_abort_dq"}, {31'd0, bus.dq_o}, 32'd0);
                chk({nm, "_abort_busy"}, {31'd0, bus.busy}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                step();
                return;
            end
        end
        step();
        if (bus.dq_oe !== 1'b0 || bus.dq_o !== 1'b0 || bus.busy !== 1'b0) oe_bad++;
        chk({nm, "_timing"}, 32'(oe_bad), 32'd0);
        chk(nm, got, exp_v);
`ifdef MEM_RESP_PARITY_EN
        chk({nm, "_par"}, {31'd0, par}, {31'd0, ^exp_v});
`else
        chk({nm, "_par_idle"}, {31'd0, par}, 32'd0);
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.cs_n    = 1'b1;
        bus.command = CMD_NOP;
        bus.RA      = '0;
        bus.CA      = '0;
        bus.dq_i    = 1'b0;

        vecs[0]  = '{OP_RST,   CMD_NOP,  4'd0,  12'h000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{OP_RAW,   CMD_RD,   4'd0,  12'h005, 32'h0000_0000, 1'b1};
        vecs[2]  = '{OP_RST,   CMD_NOP,  4'd0,  12'h000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{OP_DESEL, CMD_WR,   4'd0,  12'h005, 32'h0000_0000, 1'b0};
        vecs[4]  = '{OP_RAW,   CMD_PRE,  4'd0,  12'h000, 32'h0000_0000, 1'b0};
        vecs[5]  = '{OP_RAW,   CMD_ACT,  4'd3,  12'h000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{OP_WR,    CMD_WR,   4'd0,  12'h005, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{OP_RD,    CMD_RD,   4'd0,  12'h005, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{OP_WR,    CMD_WR,   4'd0,  12'h001, 32'h0000_0001, 1'b0};
        vecs[9]  = '{OP_WR,    CMD_WR,   4'd0,  12'h002, 32'h0000_0002, 1'b0};
        vecs[10] = '{OP_RD,    CMD_RD,   4'd0,  12'h001, 32'h0000_0001, 1'b0};
        vecs[11] = '{OP_RD,    CMD_RD,   4'd0,  12'h002, 32'h0000_0002, 1'b0};
        vecs[12] = '{OP_RD,    CMD_RD,   4'd0,  12'h007, 32'h0000_0000, 1'b0};
        vecs[13] = '{OP_WR,    CMD_WR,   4'd0,  12'h01B, 32'h1234_5678, 1'b0};
        vecs[14] = '{OP_RD,    CMD_RD,   4'd0,  12'h00B, 32'h1234_5678, 1'b0};
        vecs[15] = '{OP_RAW,   CMD_ACT,  4'hA,  12'h000, 32'h0000_0000, 1'b0};
        vecs[16] = '{OP_RD,    CMD_RD,   4'd0,  12'h005, 32'hDEAD_BEEF, 1'b0};
        vecs[17] = '{OP_RAW,   3'b110,   4'd0,  12'h000, 32'h0000_0000, 1'b1};

        for (int i = 0; i < 18; i++) begin
            case (vecs[i].op)
                OP_RST:   do_reset();
                OP_RAW:   do_raw(vecs[i].cmd, vecs[i].ra, vecs[i].ca, 1'b0, $sformatf("v%0d", i));
                OP_DESEL: do_raw(vecs[i].cmd, vecs[i].ra, vecs[i].ca, 1'b1, $sformatf("v%0d", i));
                OP_WR:    do_wr(vecs[i].ca, vecs[i].data, 1'b0, -1);
                OP_RD:    do_rd(vecs[i].ca, vecs[i].data, $sformatf("v%0d_rd", i), -1);
                default:  ;
            endcase
            chk($sformatf("v%0d_err", i), {31'd0, bus.err}, {31'd0, vecs[i].exp_err});
        end

        // ACT arriving mid-write is rejected but the burst still completes.
        do_reset();
        do_raw(CMD_ACT, 4'd3, 12'h000, 1'b0, "s1_act");
        do_wr(12'h004, 32'hA5A5_A5A5, 1'b0, 10);
        chk("s1_err", {31'd0, bus.err}, 32'd1);
        do_rd(12'h004, 32'hA5A5_A5A5, "s1_rd", -1);

        // Reset pulse during bit 10 of a read clears everything.
        do_rd(12'h004, 32'hA5A5_A5A5, "s2", 10);
        chk("s2_err", {31'd0, bus.err}, 32'd0);
        do_raw(CMD_RD, 4'd0, 12'h004, 1'b0, "s2_idle_rd");
        chk("s2_idle_err", {31'd0, bus.err}, 32'd1);
        do_reset();
        do_raw(CMD_ACT, 4'd3, 12'h000, 1'b0, "s2_act");
        do_rd(12'h004, 32'h0000_0000, "s2_rd4", -1);
        do_rd(12'h005, 32'h0000_0000, "s2_rd5", -1);
        do_rd(12'h00B, 32'h0000_0000, "s2_rdB", -1);
        chk("s2_err_final", {31'd0, bus.err}, 32'd0);

`ifdef MEM_RESP_PARITY_EN
        // A bad write parity bit suppresses the store.
        do_reset();
        do_raw(CMD_ACT, 4'd0, 12'h000, 1'b0, "s3_act");
        do_wr(12'h001, 32'h0000_0001, 1'b1, -1);
        chk("s3_err", {31'd0, bus.err}, 32'd1);
        do_rd(12'h001, 32'h0000_0000, "s3_rd", -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_dev_responder.md
MEM_DEV_RESPONDER -- requirements
Module: mem_dev_responder

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit storage words (power of two, 2..256).
REQ-002 Parameter RD_LATENCY, default 2, idle cycles between RD command and first read bit (0..7).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cs_n  input  1  chip select, active low; command sampled only when 0.
REQ-006 command  input  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101-111 reserved.
REQ-007 RA  input  4  row address, used on ACT only.
REQ-008 CA  input  12  column address, used on RD/WR only.
REQ-009 dq_i  input  1  serial write data from controller.
REQ-010 dq_o  output  1  serial read data to controller.
REQ-011 dq_oe  output  1  high while dq_o drives the bus.
REQ-012 busy  output  1  high in WR_SHIFT, RD_WAIT, RD_SHIFT.
REQ-013 err  output  1  sticky protocol error flag.

Function
REQ-014 FSM states: IDLE, ACTIVE, WR_SHIFT, RD_WAIT, RD_SHIFT.
REQ-015 Command valid when cs_n=0 at rising edge; cs_n=1 or NOP = no action, no err.
REQ-016 IDLE: ACT latches RA as open_row -> ACTIVE; PRE no-op; RD/WR/reserved ignored, err set.
REQ-017 ACTIVE: ACT re-latches open_row; PRE -> IDLE; WR -> WR_SHIFT; RD -> RD_WAIT (RD_SHIFT if RD_LATENCY=0); reserved ignored, err set.
REQ-018 Word index = low log2(DEPTH) bits of {open_row, CA}, captured at RD/WR edge.
REQ-019 Write: WR edge = edge 0; dq_i sampled at edges 1..32, bit k at edge k+1, LSB first; word stored at edge 32; -> ACTIVE at edge 32.
REQ-020 Read: RD edge = edge 0; word snapshot at edge 0; dq_oe=1 and dq_o=bit k registered at edge RD_LATENCY+1+k, k=0..31; dq_oe=0 at edge RD_LATENCY+33; -> ACTIVE then.
REQ-021 dq_o=0 whenever dq_oe=0.
REQ-022 Any non-NOP command with cs_n=0 while busy=1 ignored, err set, transfer continues unaffected.
REQ-023 New command accepted at the first edge at which state is ACTIVE (back-to-back WR/RD allowed, no gap).
REQ-024 RD of a word written in the immediately preceding burst returns new data.
REQ-025 err set on the edge of the offending command, cleared only by reset.
REQ-026 5-bit bit counter plus latency counter; no wrap beyond burst length.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, dq_o=0, dq_oe=0, busy=0, err=0, open_row=0, all counters 0.
REQ-028 All storage words cleared to 0 on reset.
REQ-029 Reset mid-burst aborts: partial write discarded, read output dropped immediately.

Configuration
REQ-030 Macro MEM_RESP_PARITY_EN defined: bursts are 33 bits, bit 32 = even parity (XOR of data bits 31:0).
REQ-031 With MEM_RESP_PARITY_EN, write parity mismatch: word not stored, err set at edge 33; read drives parity at edge RD_LATENCY+33, dq_oe falls at edge RD_LATENCY+34.
REQ-032 Without MEM_RESP_PARITY_EN: 32-bit bursts, no parity logic, timing per REQ-019/REQ-020.

Verification
REQ-033 Reset, ACT RA=3, WR CA=5 data 0xDEADBEEF, RD CA=5 -> dq_o reassembles 0xDEADBEEF, first bit at edge 3 after RD, err=0.
REQ-034 RD in IDLE after reset -> no dq_oe, err=1, state IDLE.
REQ-035 WR word 0xA5A5A5A5, ACT issued during WR_SHIFT -> err=1, word still stored, read back 0xA5A5A5A5.
REQ-036 Back-to-back WR CA=1 (0x1), WR CA=2 (0x2), RD CA=1, RD CA=2 -> reads 0x00000001, 0x00000002, no gap cycles.
REQ-037 rst_n pulse low at bit 10 of RD burst -> dq_oe=0 same cycle, state IDLE, all words read 0 after re-ACT.
REQ-038 MEM_RESP_PARITY_EN: WR 0x00000001 with parity bit 0 -> err=1, read returns 0x00000000 with parity 0.
